// File: rtl/uart_rx_axis_if.sv
// AXI-Stream byte channel carried out of the UART receiver.
// The master side drives data/valid/last; the slave side drives ready.
interface uart_rx_axis_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] axis_data;
  logic                 axis_valid;
  logic                 axis_ready;
  logic                 axis_last;

  modport master (
    output axis_data,
    output axis_valid,
    output axis_last,
    input  axis_ready
  );

  modport slave (
    input  axis_data,
    input  axis_valid,
    input  axis_last,
    output axis_ready
  );
endinterface

// File: rtl/uart_rx_axis.sv
// 8N1 UART receiver feeding a small AXI-Stream FIFO.
// Packet end (tlast) is inferred from line idle time after a byte.
module uart_rx_axis #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4,
  parameter int IDLE_BITS    = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            uart_rx,
  uart_rx_axis_if.master  axis,
  output logic            frame_err,
  output logic            overflow
);

  localparam int HALF       = CLKS_PER_BIT / 2;
  localparam int IDLE_LIMIT = IDLE_BITS * CLKS_PER_BIT;
  localparam int BW         = $clog2(CLKS_PER_BIT);
  localparam int IW         = $clog2(IDLE_LIMIT + 1);
  localparam int XW         = $clog2(DATA_BITS + 1);
  localparam int AW         = $clog2(FIFO_DEPTH);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(HALF - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_LIMIT - 1);
  localparam logic [IW-1:0] IDLE_FULL = IW'(IDLE_LIMIT);
  localparam logic [XW-1:0] BIT_LAST  = XW'(DATA_BITS - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t               state;
  logic                 rx_meta, rxs;
  logic [BW-1:0]        baud_cnt;
  logic [IW-1:0]        idle_cnt;
  logic [XW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] pend_data;
  logic                 pend_valid;

  logic                 start_ok, idle_to, stop_bad, push, push_last;

  logic [DATA_BITS:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 full, pop, accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rxs     <= rx_meta;
    end
  end

  // The pending byte is flushed on the event that decides its tlast value.
  always_comb begin
    start_ok  = (state == START) && (baud_cnt == HALF_LAST) && !rxs;
    idle_to   = (state == IDLE) && rxs && (idle_cnt == IDLE_LAST);
    stop_bad  = (state == STOP) && (baud_cnt == BAUD_LAST) && !rxs;
    push      = pend_valid && (start_ok || idle_to || stop_bad);
    push_last = !start_ok;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      idle_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      pend_data  <= '0;
      pend_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (push) pend_valid <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (!rxs) begin
            state    <= START;
            idle_cnt <= '0;
          end else if (idle_cnt != IDLE_FULL) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        START: begin
          idle_cnt <= '0;
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= rxs ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          idle_cnt <= '0;
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            shreg    <= {rxs, shreg[DATA_BITS-1:1]};
            if (bit_idx == BIT_LAST) state <= STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          idle_cnt <= '0;
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (rxs) begin
              pend_data  <= shreg;
              pend_valid <= 1'b1;
              state      <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        BREAK: begin
          idle_cnt <= '0;
          baud_cnt <= '0;
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign full   = (count == DEPTH_C);
  assign pop    = axis.axis_valid && axis.axis_ready;
  assign accept = push && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full && !pop;
      if (accept) begin
        mem[wr_ptr] <= {push_last, pend_data};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign axis.axis_valid = (count != '0);
  assign axis.axis_data  = mem[rd_ptr][DATA_BITS-1:0];
  assign axis.axis_last  = mem[rd_ptr][DATA_BITS];

endmodule

// File: tb/tb_uart_rx_axis.sv
// Bench for uart_rx_axis: serial stimulus, stream monitor, and a packet-level model
// that derives tlast from the gap that follows each byte.
module tb_uart_rx_axis;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic uart_rx = 1'b1;
  logic frame_err, overflow;

  int total = 0;
  int bad   = 0;

  uart_rx_axis_if #(.DATA_BITS(8)) bus ();

  uart_rx_axis #(
    .DATA_BITS(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .IDLE_BITS(10)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .axis(bus),
    .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  logic [7:0] obs_d[$];
  bit         obs_l[$];
  int         ferr_cnt = 0;
  int         ovf_cnt  = 0;
  int         stab_viol = 0;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_d;
  logic       prev_l;
  bit         rand_ready = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.axis_valid && bus.axis_ready) begin
        obs_d.push_back(bus.axis_data);
        obs_l.push_back(bus.axis_last);
      end
      if (frame_err) ferr_cnt++;
      if (overflow) ovf_cnt++;
      if (prev_hold && (bus.axis_data !== prev_d || bus.axis_last !== prev_l)) stab_viol++;
      prev_hold = bus.axis_valid && !bus.axis_ready;
      prev_d    = bus.axis_data;
      prev_l    = bus.axis_last;
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    bus.axis_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready) bus.axis_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    uart_rx = stop_ok;
    tick(CPB);
  endtask

  task automatic idle_bits(input int n);
    uart_rx = 1'b1;
    tick(n * CPB);
  endtask

  task automatic clear_obs();
    obs_d.delete();
    obs_l.delete();
    ferr_cnt  = 0;
    ovf_cnt   = 0;
    stab_viol = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    uart_rx = 1'b1;
    bus.axis_ready = 1'b0;
    tick(3);
    total++; if (bus.axis_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.axis_valid); end
    total++; if (bus.axis_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", bus.axis_data); end
    total++; if (bus.axis_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", bus.axis_last); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    rst = 1'b1;
    tick(4);
  endtask

  task automatic test_single();
    clear_obs();
    bus.axis_ready = 1'b1;
    send_byte(8'hA5, 1'b1);
    idle_bits(12);
    tick(10);
    total++; if (obs_d.size() !== 1) begin bad++; $display("FAIL single_count: got %0d want 1", obs_d.size()); end
    else begin
      total++; if (obs_d[0] !== 8'hA5) begin bad++; $display("FAIL single_data: got %h want a5", obs_d[0]); end
      total++; if (obs_l[0] !== 1'b1) begin bad++; $display("FAIL single_last: got %b want 1", obs_l[0]); end
    end
    total++; if (ferr_cnt + ovf_cnt !== 0) begin bad++; $display("FAIL single_err: got %0d pulses want 0", ferr_cnt + ovf_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d [3];
    exp_d = '{8'h11, 8'h22, 8'h33};
    clear_obs();
    bus.axis_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_byte(exp_d[i], 1'b1);
    idle_bits(12);
    tick(10);
    total++; if (obs_d.size() !== 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", obs_d.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs_d[i] !== exp_d[i] || obs_l[i] !== (i == 2)) begin
          bad++;
          $display("FAIL b2b_beat%0d: got %h/%b want %h/%b", i, obs_d[i], obs_l[i], exp_d[i], (i == 2));
        end
      end
    end
  endtask

  task automatic test_frame_err();
    clear_obs();
    bus.axis_ready = 1'b1;
    send_byte(8'h44, 1'b1);
    idle_bits(12);
    send_byte(8'h55, 1'b0);
    uart_rx = 1'b0;
    tick(3 * CPB);
    idle_bits(12);
    tick(10);
    total++; if (ferr_cnt !== 1) begin bad++; $display("FAIL ferr_pulses: got %0d want 1", ferr_cnt); end
    total++; if (obs_d.size() !== 1) begin bad++; $display("FAIL ferr_count: got %0d want 1", obs_d.size()); end
    else begin
      total++; if (obs_d[0] !== 8'h44 || obs_l[0] !== 1'b1) begin bad++; $display("FAIL ferr_beat: got %h/%b want 44/1", obs_d[0], obs_l[0]); end
    end
  endtask

  task automatic test_overflow();
    clear_obs();
    bus.axis_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b1);
    idle_bits(12);
    tick(10);
    total++; if (ovf_cnt !== 2) begin bad++; $display("FAIL ovf_pulses: got %0d want 2", ovf_cnt); end
    total++; if (bus.axis_valid !== 1'b1 || bus.axis_data !== 8'h01) begin bad++; $display("FAIL ovf_head: got %b/%h want 1/01", bus.axis_valid, bus.axis_data); end
    bus.axis_ready = 1'b1;
    tick(10);
    total++; if (obs_d.size() !== 4) begin bad++; $display("FAIL ovf_count: got %0d want 4", obs_d.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (obs_d[i] !== 8'(i + 1) || obs_l[i] !== 1'b0) begin
          bad++;
          $display("FAIL ovf_beat%0d: got %h/%b want %h/0", i, obs_d[i], obs_l[i], 8'(i + 1));
        end
      end
    end
    total++; if (stab_viol !== 0 || ferr_cnt !== 0) begin bad++; $display("FAIL ovf_stable: got %0d/%0d want 0/0", stab_viol, ferr_cnt); end
  endtask

  task automatic test_glitch();
    clear_obs();
    bus.axis_ready = 1'b1;
    uart_rx = 1'b0;
    tick(4);
    idle_bits(12);
    total++; if (obs_d.size() + ferr_cnt !== 0) begin bad++; $display("FAIL glitch: got %0d beats %0d ferr want 0/0", obs_d.size(), ferr_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'h3C;
    clear_obs();
    bus.axis_ready = 1'b0;
    send_byte(8'h99, 1'b1);
    idle_bits(12);
    tick(5);
    total++; if (bus.axis_valid !== 1'b1) begin bad++; $display("FAIL rmid_prefill: got %b want 1", bus.axis_valid); end
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    rst = 1'b0;
    #1;
    total++; if (bus.axis_valid !== 1'b0 || bus.axis_data !== 8'h00 || bus.axis_last !== 1'b0) begin
      bad++; $display("FAIL rmid_outputs: got %b/%h/%b want 0/00/0", bus.axis_valid, bus.axis_data, bus.axis_last);
    end
    tick(2);
    uart_rx = 1'b1;
    rst = 1'b1;
    idle_bits(3);
    clear_obs();
    bus.axis_ready = 1'b1;
    send_byte(8'h7E, 1'b1);
    idle_bits(12);
    tick(10);
    total++; if (obs_d.size() !== 1) begin bad++; $display("FAIL rmid_count: got %0d want 1", obs_d.size()); end
    else begin
      total++; if (obs_d[0] !== 8'h7E || obs_l[0] !== 1'b1) begin bad++; $display("FAIL rmid_beat: got %h/%b want 7e/1", obs_d[0], obs_l[0]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_d[$];
    bit         exp_l[$];
    logic [7:0] b;
    bit         long_gap;
    int         guard;
    clear_obs();
    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom_range(0, 255));
      long_gap = (i == 19) || ($urandom_range(0, 2) == 0);
      exp_d.push_back(b);
      exp_l.push_back(long_gap);
      send_byte(b, 1'b1);
      if (long_gap) idle_bits(12 + int'($urandom_range(0, 4)));
    end
    guard = 0;
    while (bus.axis_valid === 1'b1 && guard < 2000) begin
      tick(1);
      guard++;
    end
    tick(4);
    rand_ready = 1'b0;
    total++; if (guard >= 2000) begin bad++; $display("FAIL rand_drain: got timeout want empty"); end
    total++; if (obs_d.size() !== exp_d.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", obs_d.size(), exp_d.size()); end
    else begin
      for (int i = 0; i < exp_d.size(); i++) begin
        total++;
        if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
          bad++;
          $display("FAIL rand_beat%0d: got %h/%b want %h/%b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
        end
      end
    end
    total++; if (ferr_cnt + ovf_cnt + stab_viol !== 0) begin
      bad++; $display("FAIL rand_side: got ferr=%0d ovf=%0d unstable=%0d want 0", ferr_cnt, ovf_cnt, stab_viol);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_overflow();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
